// File: rtl/uart16550_tx.sv
// UART16550 transmit serializer.
// Takes characters from the Tx FIFO and sends them as a start bit, 5-8 data
// bits (LSB first), an optional parity bit and 1/1.5/2 stop bits. Bit timing
// comes from the 16x baud strobe. The serial output is registered.
module uart16550_tx (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       baud16_i,
   input  logic [7:0] lcr_i,
   input  logic       fifo_empty_i,
   input  logic [7:0] fifo_q_i,
   output logic       fifo_rd_o,
   output logic       sout_o,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [3:0]  tick_q, tick_d;
   logic [2:0]  bcnt_q, bcnt_d;
   logic [1:0]  wls_q, wls_d;
   logic        stb_q, stb_d;
   logic        pen_q, pen_d;
   logic        par_q, par_d;
   logic        line_d;
   logic        sout_d;
   logic        bit_end;
   logic        stop_end;
   logic [7:0]  data_mask;
   logic        fetch_par;

   // The divisor latch access bit has no meaning for the transmitter.
   logic        unused_dlab;
   assign unused_dlab = lcr_i[7];

   // A normal bit period ends on the strobe that wraps the tick counter.
   assign bit_end = baud16_i && (tick_q == 4'd15);

   // Stop period: 16 strobes, or 24 (5-bit words) / 32 strobes with stb set.
   // The bit counter extends the 4-bit tick counter past one bit here.
   assign stop_end = baud16_i &&
                     (stb_q ? ((bcnt_q == 3'd1) &&
                               (tick_q == ((wls_q == 2'b00) ? 4'd7 : 4'd15)))
                            : (tick_q == 4'd15));

   // Parity of the incoming character, computed over the selected word length only.
   always_comb begin
      data_mask = 8'hFF;
      case (lcr_i[1:0])
         2'b00:   data_mask = 8'h1F;
         2'b01:   data_mask = 8'h3F;
         2'b10:   data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
      if (lcr_i[5]) begin
         fetch_par = ~lcr_i[4];
      end else if (lcr_i[4]) begin
         fetch_par = ^(fifo_q_i & data_mask);
      end else begin
         fetch_par = ~(^(fifo_q_i & data_mask));
      end
   end

   // Next-state logic, FIFO pop and line value.
   // The line value is taken from the next state, so the registered output
   // shows the start bit in the first cycle after the pop.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      tick_d    = baud16_i ? tick_q + 4'd1 : tick_q;
      bcnt_d    = bcnt_q;
      wls_d     = wls_q;
      stb_d     = stb_q;
      pen_d     = pen_q;
      par_d     = par_q;
      fifo_rd_o = 1'b0;

      case (state_q)
         IDLE: begin
            tick_d = '0;
            bcnt_d = '0;
            if (!fifo_empty_i && !rst_i) begin
               fifo_rd_o = 1'b1;
               shift_d   = fifo_q_i;
               wls_d     = lcr_i[1:0];
               stb_d     = lcr_i[2];
               pen_d     = lcr_i[3];
               par_d     = fetch_par;
               state_d   = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bcnt_q == {1'b1, wls_q}) begin
                  bcnt_d  = '0;
                  state_d = pen_q ? PARITY : STOP;
               end else begin
                  bcnt_d = bcnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (stop_end) begin
               state_d = IDLE;
            end else if (bit_end) begin
               bcnt_d = bcnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      case (state_d)
         START:   line_d = 1'b0;
         DATA:    line_d = shift_d[0];
         PARITY:  line_d = par_q;
         default: line_d = 1'b1;
      endcase

      // Break is applied live on top of the frame, which keeps running.
      sout_d = lcr_i[6] ? 1'b0 : line_d;
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         shift_q <= '0;
         tick_q  <= '0;
         bcnt_q  <= '0;
         wls_q   <= '0;
         stb_q   <= 1'b0;
         pen_q   <= 1'b0;
         par_q   <= 1'b0;
         sout_o  <= 1'b1;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         tick_q  <= tick_d;
         bcnt_q  <= bcnt_d;
         wls_q   <= wls_d;
         stb_q   <= stb_d;
         pen_q   <= pen_d;
         par_q   <= par_d;
         sout_o  <= sout_d;
      end
   end

   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_uart16550_tx.sv
// Testbench for uart16550_tx: a queue-backed Tx FIFO and a per-clock
// waveform model of each frame built from the line-format rules.
module tb_uart16550_tx;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       baud16_i;
   logic [7:0] lcr_i;
   logic       fifo_empty_i;
   logic [7:0] fifo_q_i;
   logic       fifo_rd_o;
   logic       sout_o;
   logic       busy_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0]  mem [0:63];
   int unsigned head = 0;
   int unsigned tail = 0;
   logic [7:0]  exp_bytes[$];
   logic        exp_line[$];

   always #5 clk = ~clk;

   uart16550_tx dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .baud16_i     (baud16_i),
      .lcr_i        (lcr_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_q_i     (fifo_q_i),
      .fifo_rd_o    (fifo_rd_o),
      .sout_o       (sout_o),
      .busy_o       (busy_o)
   );

   // Show-ahead FIFO model.
   assign fifo_empty_i = (head == tail);
   assign fifo_q_i     = mem[head % 64];

   // Pop on the clock edge that consumes the read strobe.
   always @(posedge clk) begin
      if (fifo_rd_o) head <= head + 1;
   end

   task automatic check1(input string tag, input logic got, input logic exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[tail % 64] = b;
      tail++;
      exp_bytes.push_back(b);
      #1;
   endtask

   // Expected line level for every clock of a frame (baud strobe every clock).
   task automatic model_frame(input logic [7:0] lcr, input logic [7:0] d);
      int unsigned nb, ones, stop_len;
      logic p;
      exp_line.delete();
      nb = 5 + lcr[1:0];
      repeat (16) exp_line.push_back(1'b0);
      ones = 0;
      for (int unsigned i = 0; i < nb; i++) begin
         ones += d[i];
         repeat (16) exp_line.push_back(d[i]);
      end
      if (lcr[3]) begin
         if (lcr[5])      p = ~lcr[4];
         else if (lcr[4]) p = (ones % 2 == 1);
         else             p = (ones % 2 == 0);
         repeat (16) exp_line.push_back(p);
      end
      stop_len = !lcr[2] ? 16 : ((nb == 5) ? 24 : 32);
      repeat (stop_len) exp_line.push_back(1'b1);
   endtask

   task automatic wait_pop(input string tag, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (fifo_rd_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_assert++;
      assert (ok) else begin
         n_fail++;
         $error("FAIL %s_pop_timeout: observed no fifo_rd_o expected a pop", tag);
      end
   endtask

   // Waits for the pop, then checks every clock of the frame and the idle cycle after it.
   task automatic check_frame(input string tag, input int chg_at, input logic [7:0] chg_lcr,
                              input int brk_on, input int brk_off);
      logic ok, brk;
      logic [7:0] d;
      wait_pop(tag, ok);
      if (!ok) return;
      d = exp_bytes.pop_front();
      model_frame(lcr_i, d);
      check1({tag, "_busy_at_pop"}, busy_o, 1'b0);
      brk = 1'b0;
      for (int k = 0; k < exp_line.size(); k++) begin
         @(negedge clk);
         check1({tag, "_sout"}, sout_o, brk ? 1'b0 : exp_line[k]);
         check1({tag, "_busy"}, busy_o, 1'b1);
         check1({tag, "_no_pop"}, fifo_rd_o, 1'b0);
         if (k == chg_at)  lcr_i = chg_lcr;
         if (k == brk_on)  begin lcr_i[6] = 1'b1; brk = 1'b1; end
         if (k == brk_off) begin lcr_i[6] = 1'b0; brk = 1'b0; end
      end
      @(negedge clk);
      check1({tag, "_busy_end"}, busy_o, 1'b0);
      check1({tag, "_sout_gap"}, sout_o, 1'b1);
   endtask

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic ok;
      logic [7:0] rl, rd;
      rst_i    = 1'b1;
      baud16_i = 1'b1;
      lcr_i    = 8'h03;
      repeat (3) @(negedge clk);
      check1("reset_sout", sout_o, 1'b1);
      check1("reset_busy", busy_o, 1'b0);
      check1("reset_rd", fifo_rd_o, 1'b0);
      rst_i = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check1("idle_rd", fifo_rd_o, 1'b0);
         check1("idle_busy", busy_o, 1'b0);
      end

      // 8N1
      lcr_i = 8'h03; push(8'hA5);
      check_frame("8n1", -1, 8'h00, -1, -1);
      // 7E1
      @(negedge clk); lcr_i = 8'h1A; push(8'h35);
      check_frame("7e1", -1, 8'h00, -1, -1);
      // 5 bits, 1.5 stop, odd parity
      @(negedge clk); lcr_i = 8'h0C; push(8'h1F);
      check_frame("5o15", -1, 8'h00, -1, -1);
      // stick parity
      @(negedge clk); lcr_i = 8'h3B; push(8'h00);
      check_frame("stick0", -1, 8'h00, -1, -1);
      @(negedge clk); lcr_i = 8'h2B; push(8'hFF);
      check_frame("stick1", -1, 8'h00, -1, -1);
      // 8 bits, 2 stop
      @(negedge clk); lcr_i = 8'h07; push(8'h6C);
      check_frame("8n2", -1, 8'h00, -1, -1);

      // back-to-back with an LCR change during the first frame
      @(negedge clk); lcr_i = 8'h03;
      push(8'h55); push(8'hAA);
      check_frame("b2b_first", 40, 8'h1B, -1, -1);
      check_frame("b2b_second", -1, 8'h00, -1, -1);

      // break mid-frame; the next byte is still fetched
      @(negedge clk); lcr_i = 8'h03;
      push(8'h3C); push(8'h81);
      check_frame("break", -1, 8'h00, 30, 70);
      check_frame("after_break", -1, 8'h00, -1, -1);

      // reset mid-DATA
      @(negedge clk); lcr_i = 8'h03; push(8'h96);
      wait_pop("rst_frame", ok);
      void'(exp_bytes.pop_front());
      repeat (40) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      check1("midrst_sout", sout_o, 1'b1);
      check1("midrst_busy", busy_o, 1'b0);
      check1("midrst_rd", fifo_rd_o, 1'b0);
      rst_i = 1'b0;
      repeat (20) begin
         @(negedge clk);
         check1("postrst_sout", sout_o, 1'b1);
         check1("postrst_busy", busy_o, 1'b0);
         check1("postrst_rd", fifo_rd_o, 1'b0);
      end

      // randomized formats and data; dlab random, break off
      for (int n = 0; n < 12; n++) begin
         rl = 8'($urandom) & 8'hBF;
         rd = 8'($urandom);
         lcr_i = rl;
         push(rd);
         check_frame("rand", -1, 8'h00, -1, -1);
         @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/uart16550_tx.md
# uart16550_tx

Transmit serializer for the UART16550. Pops characters from the Tx FIFO and shifts them out on the serial line as start bit, 5–8 data bits (LSB first), optional parity and 1/1.5/2 stop bits, all timed by the 16x baud strobe from the baud generator. Sits between the Tx FIFO and the `sout` pad/loopback mux. Supplies the busy indication used for LSR.TEMT.

## Interface

Parameters: none.

- `clk_i`  input  1  system clock; the only clock
- `rst_i`  input  1  synchronous, active-high reset
- `baud16_i`  input  1  one-cycle strobe at 16x the baud rate
- `lcr_i`  input  8  Line Control Register, lcr_t layout: dlab, set_break, stick_parity, eps, pen, stb, wls
- `fifo_empty_i`  input  1  Tx FIFO empty
- `fifo_q_i`  input  8  Tx FIFO head; show-ahead, valid whenever `fifo_empty_i`=0
- `fifo_rd_o`  output  1  one-cycle pop pulse
- `sout_o`  output  1  serial output, registered; idle/mark = 1
- `busy_o`  output  1  a character is being shifted; 0 only in IDLE

## Operation

- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - When `fifo_empty_i`=0, assert `fifo_rd_o` for that one cycle.
  - In the same cycle, latch `fifo_q_i` into the shift register and latch `lcr_i` (wls, stb, pen, eps, stick_parity).
  - Clear the tick counter and bit counter, then go to START.
  - A change to `lcr_i` after the latch has no effect on the current frame.
- **Tick counter** (4-bit)
  - Increments only on `baud16_i`.
  - A bit period ends on the strobe that takes the counter to its terminal count: 16 strobes per bit.
  - In STOP the terminal count is 16, 24 or 32 strobes.
- **START**: line = 0 for one bit period, then go to DATA.
- **DATA**
  - Line = shift_reg[0]; shift right at the end of each bit.
  - Bit count is 5/6/7/8 for wls 00/01/10/11.
  - After the last data bit, go to PARITY if pen=1, else STOP.
- **Parity** is computed over the wls-masked data only.
  - pen=1, stick=0, eps=1 (even): bit = XOR(data).
  - pen=1, stick=0, eps=0 (odd): bit = ~XOR(data).
  - stick=1: bit = ~eps, so eps=1 sends 0 and eps=0 sends 1.
  - Duration is one bit period.
- **STOP**
  - Line = 1.
  - Length is 16 strobes when stb=0.
  - With stb=1, length is 24 strobes (1.5 bits) when wls=00, otherwise 32 strobes.
  - At the end, go to IDLE. If the FIFO is non-empty, IDLE fetches the next character on the following cycle.
- **Break**
  - `lcr_i.set_break`=1 forces `sout_o`=0 from the next cycle.
  - It is applied live, not latched.
  - The FSM keeps running, so characters are still consumed.
  - Releasing the break restores the FSM line value on the next cycle.
- `lcr_i.dlab` is ignored.
- `busy_o` = (state ≠ IDLE).

## Timing

- Reset values: state IDLE, `sout_o`=1, `fifo_rd_o`=0, `busy_o`=0, counters 0.
- Reset mid-frame:
  - On the next edge, `sout_o`=1 and state is IDLE.
  - The character in flight is lost; the FIFO is not popped again for it.
- **Fetch latency**
  - Cycle N: `fifo_empty_i`=0 in IDLE, so `fifo_rd_o`=1.
  - N+1: `sout_o`=0 (start bit) and `busy_o`=1.
- **Bit duration**
  - From the first line change of a bit to the next line change is exactly 16 `baud16_i` strobes, plus the one-cycle registered output delay.
  - The start bit spans from N+1 to the cycle after its 16th strobe.
- **Back-to-back frames**: the last STOP strobe at cycle M gives IDLE at M+1, `fifo_rd_o` at M+1 and start bit at M+2. The inter-frame gap is 1 clk.
- `fifo_rd_o` never asserts outside IDLE and never when `fifo_empty_i`=1.
- If `baud16_i` is held high every cycle, a bit is 16 clocks.

## Test plan

All scenarios drive `baud16_i`=1 every cycle.

- **8N1 (lcr=0x03), push 0xA5**
  - `fifo_rd_o` pulses once.
  - `sout_o`: 0, then 1,0,1,0,0,1,0,1, then 1, each for 16 clk.
  - `busy_o` falls 160 clk after the start bit.
- **7E1 (lcr=0x1A), push 0x35**: data bits 1,0,1,0,1,1,0, parity 0, then a 1-bit stop.
- **5-bit, 1.5 stop, odd parity (lcr=0x0C), push 0x1F**
  - Data 1,1,1,1,1, parity 0.
  - Stop high for 24 clk, then `busy_o`=0.
- **Stick parity**
  - lcr=0x3B with 0x00 sends parity 0.
  - lcr=0x2B with 0xFF sends parity 1.
- **Back-to-back and mid-frame LCR change**
  - Preload 0x55 and 0xAA under 8N1; change lcr to 0x1B during the first frame.
  - First frame stays 8N1. Second frame carries even parity (bit 0).
  - The high line between the frames is 16+1 clk.
- **Break and reset**
  - set_break=1 mid-frame: `sout_o`=0 on the next cycle, and the frame still completes and pops the next byte.
  - `rst_i` asserted mid-DATA: next cycle `sout_o`=1 and `busy_o`=0, with no extra `fifo_rd_o`.
